// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit active-low 7-segment scan controller for received command bytes
// Optional: define SEG_GHOST_BLANK_EN to blank AN for the first 2 clocks of every digit slot.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_TICKS  = 2000,
    parameter int HOLD_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:1] C,
    output logic [3:0] AN,
    output logic [1:0] digit_sel,
    output logic       active,
    output logic       err_flag
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]     PRE_MAX   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]     PRE_ONE   = PW'(1);
    localparam logic [PW-1:0]     PRE_TWO   = PW'(2);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [6:0]        SEG_BLANK = 7'h7F;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state;
    logic [PW-1:0]     prescaler;
    logic [HOLD_W-1:0] hold_cnt;
    logic [7:0]        byte_q;
    logic              tick;
    logic [3:0]        an_next;
    logic [6:0]        c_next;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
        endcase
    endfunction

    // Commands occupy exactly 0x70..0x77: left glyph is U/b, right glyph is L/r.
    function automatic logic [6:0] left_glyph(input logic [7:0] b);
        case (b)
            8'h74, 8'h71, 8'h70: left_glyph = 7'h41;
            8'h76, 8'h73, 8'h72: left_glyph = 7'h03;
            default:             left_glyph = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] right_glyph(input logic [7:0] b);
        case (b)
            8'h77, 8'h71, 8'h73: right_glyph = 7'h47;
            8'h75, 8'h70, 8'h72: right_glyph = 7'h4E;
            default:             right_glyph = SEG_BLANK;
        endcase
    endfunction

    assign tick = (prescaler == PRE_MAX);

    always_comb begin
        an_next = 4'b1111;
        c_next  = SEG_BLANK;
        if (state == SHOW) begin
            case (digit_sel)
                2'd0: begin an_next = 4'b1110; c_next = right_glyph(byte_q);   end
                2'd1: begin an_next = 4'b1101; c_next = left_glyph(byte_q);    end
                2'd2: begin an_next = 4'b1011; c_next = hex_seg(byte_q[3:0]);  end
                default: begin an_next = 4'b0111; c_next = hex_seg(byte_q[7:4]); end
            endcase
        end
`ifdef SEG_GHOST_BLANK_EN
        if (prescaler < PRE_TWO) an_next = 4'b1111;
`else
        if (PRE_TWO == '0) an_next = 4'b1111;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            hold_cnt  <= '0;
            byte_q    <= 8'h00;
            digit_sel <= 2'd0;
            AN        <= 4'b1111;
            C         <= SEG_BLANK;
            active    <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PRE_ONE;
            if (tick) digit_sel <= digit_sel + 2'd1;
            AN <= an_next;
            C  <= c_next;
            // A strobe always wins over a coincident expiry tick.
            if (rx_valid) begin
                byte_q   <= rx_data;
                hold_cnt <= HOLD_LOAD;
                err_flag <= (rx_data[7:3] != 5'b01110);
                state    <= SHOW;
                active   <= 1'b1;
            end else if (state == SHOW && tick && HOLD_TICKS != 0) begin
                hold_cnt <= hold_cnt - HOLD_ONE;
                if (hold_cnt == HOLD_ONE) begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;
    localparam int DIV  = 4;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:1] C, C0;
    logic [3:0] AN, AN0;
    logic [1:0] digit_sel, digit_sel0;
    logic       active, active0, err_flag, err_flag0;

    seg_scan_ctrl #(.REFRESH_DIV(DIV), .HOLD_TICKS(HOLD), .HOLD_W(16)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .C(C), .AN(AN), .digit_sel(digit_sel), .active(active), .err_flag(err_flag));

    seg_scan_ctrl #(.REFRESH_DIV(DIV), .HOLD_TICKS(0), .HOLD_W(16)) dut_nohold (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .C(C0), .AN(AN0), .digit_sel(digit_sel0), .active(active0), .err_flag(err_flag0));

    always #5 clk = ~clk;

    typedef struct {
        bit         show;
        int         digit;
        int         presc;
        logic [7:0] byt;
        bit         err;
    } view_t;

    int         checks = 0;
    int         errors = 0;
    int         n;
    bit         have;
    int         last_s;
    logic [7:0] byt;
    view_t      cur, prev;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    // {left, right} glyph pair straight from the command table
    function automatic logic [13:0] glyphs(input logic [7:0] b);
        case (b)
            8'h74: return {7'h41, 7'h7F};
            8'h76: return {7'h03, 7'h7F};
            8'h77: return {7'h7F, 7'h47};
            8'h75: return {7'h7F, 7'h4E};
            8'h71: return {7'h41, 7'h47};
            8'h70: return {7'h41, 7'h4E};
            8'h73: return {7'h03, 7'h47};
            8'h72: return {7'h03, 7'h4E};
            default: return {7'h7F, 7'h7F};
        endcase
    endfunction

    // Edge at which a strobe on edge s runs out: the HOLD-th tick after s.
    function automatic int expire_edge(input int s);
        return (((s + 1) / DIV) + HOLD) * DIV - 1;
    endfunction

    function automatic view_t view(input int e);
        view_t v;
        v.show  = have && (e < expire_edge(last_s));
        v.digit = ((e + 1) / DIV) % 4;
        v.presc = (e + 1) % DIV;
        v.byt   = byt;
        v.err   = have && (glyphs(byt) == {7'h7F, 7'h7F});
        return v;
    endfunction

    function automatic logic [3:0] exp_an(input view_t v);
        logic [3:0] a = 4'b1111;
        if (v.show) a[v.digit] = 1'b0;
`ifdef SEG_GHOST_BLANK_EN
        if (v.presc < 2) a = 4'b1111;
`endif
        return a;
    endfunction

    function automatic logic [6:0] exp_c(input view_t v);
        logic [13:0] g = glyphs(v.byt);
        if (!v.show) return 7'h7F;
        case (v.digit)
            0: return g[6:0];
            1: return g[13:7];
            2: return hex7(v.byt[3:0]);
            default: return hex7(v.byt[7:4]);
        endcase
    endfunction

    task automatic model_reset();
        n = -1; have = 0; last_s = 0; byt = 8'h00;
        cur = view(-1); prev = cur;
    endtask

    task automatic step(input bit v, input logic [7:0] d);
        rx_valid = v; rx_data = d;
        @(posedge clk);
        n++;
        if (v) begin have = 1; last_s = n; byt = d; end
        prev = cur;
        cur = view(n);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks += 5;
        if (AN !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", AN); end
        if (C !== 7'h7F) begin errors++; $display("FAIL reset_c got %h exp 7f", C); end
        if (digit_sel !== 2'd0) begin errors++; $display("FAIL reset_digit got %0d exp 0", digit_sel); end
        if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", active); end
        if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_flag); end
    endtask

    task automatic test_idle_scan();
        for (int i = 0; i < 40; i++) begin
            step(0, 8'h00);
            checks += 4;
            if (AN !== 4'b1111) begin errors++; $display("FAIL idle_an n=%0d got %b exp 1111", n, AN); end
            if (C !== 7'h7F) begin errors++; $display("FAIL idle_c n=%0d got %h exp 7f", n, C); end
            if (active !== 1'b0) begin errors++; $display("FAIL idle_active n=%0d got %b exp 0", n, active); end
            if (digit_sel !== 2'(((n + 1) / DIV) % 4)) begin
                errors++; $display("FAIL idle_digit n=%0d got %0d exp %0d", n, digit_sel, ((n + 1) / DIV) % 4);
            end
        end
    endtask

    task automatic test_command(input logic [7:0] b, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(i == 0, b);
            checks += 5;
            if (AN !== exp_an(prev)) begin errors++; $display("FAIL cmd_an b=%h n=%0d got %b exp %b", b, n, AN, exp_an(prev)); end
            if (C !== exp_c(prev)) begin errors++; $display("FAIL cmd_c b=%h n=%0d got %h exp %h", b, n, C, exp_c(prev)); end
            if (digit_sel !== 2'(cur.digit)) begin errors++; $display("FAIL cmd_digit n=%0d got %0d exp %0d", n, digit_sel, cur.digit); end
            if (active !== cur.show) begin errors++; $display("FAIL cmd_active b=%h n=%0d got %b exp %b", b, n, active, cur.show); end
            if (err_flag !== cur.err) begin errors++; $display("FAIL cmd_err b=%h n=%0d got %b exp %b", b, n, err_flag, cur.err); end
        end
    endtask

    task automatic test_expiry();
        int lit = 0;
        int s;
        step(1, 8'h76);
        s = n;
        for (int i = 0; i < 24; i++) begin
            step(0, 8'h00);
            if (active === 1'b1) lit++;
            checks += 2;
            if (active !== cur.show) begin errors++; $display("FAIL exp_active n=%0d got %b exp %b", n, active, cur.show); end
            if (AN !== exp_an(prev) || C !== exp_c(prev)) begin
                errors++; $display("FAIL exp_out n=%0d got %b/%h exp %b/%h", n, AN, C, exp_an(prev), exp_c(prev));
            end
        end
        checks++;
        if (lit + 1 !== expire_edge(s) - s) begin
            errors++; $display("FAIL exp_length got %0d exp %0d", lit + 1, expire_edge(s) - s);
        end
    endtask

    task automatic test_coincident();
        int e;
        step(1, 8'h70);
        e = expire_edge(n);
        while (n + 1 < e) step(0, 8'h00);
        step(1, 8'h72);
        checks++;
        if (active !== 1'b1) begin errors++; $display("FAIL coin_active got %b exp 1", active); end
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00);
            checks += 3;
            if (active !== cur.show) begin errors++; $display("FAIL coin_active n=%0d got %b exp %b", n, active, cur.show); end
            if (AN !== exp_an(prev)) begin errors++; $display("FAIL coin_an n=%0d got %b exp %b", n, AN, exp_an(prev)); end
            if (C !== exp_c(prev)) begin errors++; $display("FAIL coin_c n=%0d got %h exp %h", n, C, exp_c(prev)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            step(i < 5, (i % 2 == 0) ? d : 8'h70 + 8'($urandom_range(0, 7)));
            checks += 4;
            if (AN !== exp_an(prev)) begin errors++; $display("FAIL b2b_an n=%0d got %b exp %b", n, AN, exp_an(prev)); end
            if (C !== exp_c(prev)) begin errors++; $display("FAIL b2b_c n=%0d got %h exp %h", n, C, exp_c(prev)); end
            if (active !== cur.show) begin errors++; $display("FAIL b2b_active n=%0d got %b exp %b", n, active, cur.show); end
            if (err_flag !== cur.err) begin errors++; $display("FAIL b2b_err n=%0d got %b exp %b", n, err_flag, cur.err); end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit v;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) == 0);
            d = ($urandom_range(0, 1) == 0) ? 8'h70 + 8'($urandom_range(0, 7)) : 8'($urandom);
            step(v, d);
            checks += 6;
            if (AN !== exp_an(prev)) begin errors++; $display("FAIL rnd_an n=%0d got %b exp %b", n, AN, exp_an(prev)); end
            if (C !== exp_c(prev)) begin errors++; $display("FAIL rnd_c n=%0d got %h exp %h", n, C, exp_c(prev)); end
            if (digit_sel !== 2'(cur.digit)) begin errors++; $display("FAIL rnd_digit n=%0d got %0d exp %0d", n, digit_sel, cur.digit); end
            if (active !== cur.show) begin errors++; $display("FAIL rnd_active n=%0d got %b exp %b", n, active, cur.show); end
            if (err_flag !== cur.err) begin errors++; $display("FAIL rnd_err n=%0d got %b exp %b", n, err_flag, cur.err); end
            if (active0 !== have) begin errors++; $display("FAIL nohold_active n=%0d got %b exp %b", n, active0, have); end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 8'h71);
        step(0, 8'h00);
        step(0, 8'h00);
        checks++;
        if (active !== 1'b1) begin errors++; $display("FAIL rstmid_pre_active got %b exp 1", active); end
        #2 reset = 1'b1;
        #1;
        test_reset();
        checks++;
        if (active0 !== 1'b0) begin errors++; $display("FAIL rstmid_nohold got %b exp 0", active0); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        model_reset();
        test_idle_scan();
        test_command(8'h71, 20);
        test_command(8'hA5, 20);
        test_expiry();
        test_coincident();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_reset_mid();
        test_command(8'h75, 24);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
